signed_division_sequencer: RTL and testbench

SIGNED_DIVISION_SEQUENCER -- requirements
Module: signed_division_sequencer

---
 rtl/signed_division_sequencer_pkg.sv | 25 ++
 rtl/signed_division_sequencer_sign_magnitude_fix.sv | 21 ++
 rtl/signed_division_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_signed_division_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_division_sequencer_pkg.sv
// Shared definitions for the signed division sequencer: operand width,
// the magnitude of the most negative 16-bit value, and the FSM state set.
package signed_division_sequencer_pkg;

  localparam int OPW = 16;

  // |-32768| does not fit in a positive int16; as an unsigned magnitude it is 0x8000.
  localparam logic [OPW-1:0] INT16_MIN_MAG = 16'h8000;
  localparam logic [OPW-1:0] ALL_ONES      = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIX   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // The only signed pair whose true quotient (+32768) is not representable.
  function automatic logic is_overflow_pair(input logic [OPW-1:0] dividend,
                                            input logic [OPW-1:0] divisor);
    return (dividend == INT16_MIN_MAG) && (divisor == ALL_ONES);
  endfunction

endpackage

// File: rtl/signed_division_sequencer_sign_magnitude_fix.sv
// Combinational negate-if unit. Used to take operand magnitudes (negate when
// the sign bit is set) and to restore result signs after the unsigned divide.
// Negation is modulo 2^16, so 0x8000 maps to itself.
module sign_magnitude_fix
  import signed_division_sequencer_pkg::*;
(
  input  logic [OPW-1:0] i_value,
  input  logic           i_negate,
  output logic [OPW-1:0] o_value
);

  // Two's-complement negate when requested, pass-through otherwise.
  always_comb begin
    if (i_negate) begin
      o_value = ~i_value + 16'd1;
    end else begin
      o_value = i_value;
    end
  end

endmodule

// File: rtl/signed_division_sequencer.sv
// Signed division sequencer: wraps an external unsigned divider, converting
// two's-complement operands to magnitudes and fixing result signs for
// truncating division (quotient toward zero, remainder follows dividend).
// Optional build macro: DIV_ZERO_BYPASS_EN -- a zero divisor skips the divider
// and goes straight to HOLD with quotient 0xFFFF and remainder = dividend.
module signed_division_sequencer
  import signed_division_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_dividend,
  input  logic [OPW-1:0] in_divisor,
  output logic           div_start,
  output logic [OPW-1:0] div_dividend,
  output logic [OPW-1:0] div_divisor,
  input  logic           div_done,
  input  logic [OPW-1:0] div_quotient,
  input  logic [OPW:0]   div_remainder,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_quotient,
  output logic [OPW-1:0] out_remainder,
  output logic           out_div_zero,
  output logic           out_overflow
);

  state_t         r_state;
  state_t         w_state_next;
  logic           r_wait_first;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_div_zero;
  logic           r_overflow;
  logic [OPW-1:0] r_div_dividend;
  logic [OPW-1:0] r_div_divisor;
  logic [OPW-1:0] r_raw_quotient;
  logic [OPW-1:0] r_raw_remainder;
  logic [OPW-1:0] r_out_quotient;
  logic [OPW-1:0] r_out_remainder;
  logic           r_out_div_zero;
  logic           r_out_overflow;

  logic           w_take;
  logic           w_in_div_zero;
  logic           w_done_taken;
  logic [OPW-1:0] w_mag_dividend;
  logic [OPW-1:0] w_mag_divisor;
  logic [OPW-1:0] w_fix_quotient;
  logic [OPW-1:0] w_fix_remainder;
  logic           w_unused_rem_msb;

  // The divider's remainder is one bit wider than any magnitude it can produce.
  assign w_unused_rem_msb = div_remainder[OPW];

  // rst gates in_ready so it is low for the whole reset window, even though
  // the state register already reads IDLE after the first reset edge.
  assign in_ready      = (r_state == ST_IDLE) && !rst;
  assign w_take        = in_valid && in_ready;
  assign w_in_div_zero = (in_divisor == 16'd0);
  // The first WAIT cycle may still see div_done from the previous operation.
  assign w_done_taken  = (r_state == ST_WAIT) && !r_wait_first && div_done;

  assign div_start     = (r_state == ST_START);
  assign div_dividend  = r_div_dividend;
  assign div_divisor   = r_div_divisor;
  assign out_valid     = (r_state == ST_HOLD);
  assign out_quotient  = r_out_quotient;
  assign out_remainder = r_out_remainder;
  assign out_div_zero  = r_out_div_zero;
  assign out_overflow  = r_out_overflow;

  sign_magnitude_fix u_mag_dividend (
    .i_value  (in_dividend),
    .i_negate (in_dividend[OPW-1]),
    .o_value  (w_mag_dividend)
  );

  sign_magnitude_fix u_mag_divisor (
    .i_value  (in_divisor),
    .i_negate (in_divisor[OPW-1]),
    .o_value  (w_mag_divisor)
  );

  sign_magnitude_fix u_fix_quotient (
    .i_value  (r_raw_quotient),
    .i_negate (r_neg_q),
    .o_value  (w_fix_quotient)
  );

  sign_magnitude_fix u_fix_remainder (
    .i_value  (r_raw_remainder),
    .i_negate (r_neg_r),
    .o_value  (w_fix_remainder)
  );

  // Next-state decode for IDLE -> START -> WAIT -> FIX -> HOLD -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
`ifdef DIV_ZERO_BYPASS_EN
          if (w_in_div_zero) begin
            w_state_next = ST_HOLD;
          end else begin
            w_state_next = ST_START;
          end
`else
          w_state_next = ST_START;
`endif
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done_taken) begin
          w_state_next = ST_FIX;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_FIX:  w_state_next = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_HOLD;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, operand capture, raw divider results and signed result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_wait_first    <= 1'b0;
      r_neg_q         <= 1'b0;
      r_neg_r         <= 1'b0;
      r_div_zero      <= 1'b0;
      r_overflow      <= 1'b0;
      r_div_dividend  <= 16'd0;
      r_div_divisor   <= 16'd0;
      r_raw_quotient  <= 16'd0;
      r_raw_remainder <= 16'd0;
      r_out_quotient  <= 16'd0;
      r_out_remainder <= 16'd0;
      r_out_div_zero  <= 1'b0;
      r_out_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_div_dividend <= w_mag_dividend;
            r_div_divisor  <= w_mag_divisor;
            r_neg_q        <= in_dividend[OPW-1] ^ in_divisor[OPW-1];
            r_neg_r        <= in_dividend[OPW-1];
            r_div_zero     <= w_in_div_zero;
            r_overflow     <= is_overflow_pair(in_dividend, in_divisor);
`ifdef DIV_ZERO_BYPASS_EN
            if (w_in_div_zero) begin
              r_out_quotient  <= ALL_ONES;
              r_out_remainder <= in_dividend;
              r_out_div_zero  <= 1'b1;
              r_out_overflow  <= 1'b0;
            end
`endif
          end
        end
        ST_START: r_wait_first <= 1'b1;
        ST_WAIT: begin
          r_wait_first <= 1'b0;
          if (w_done_taken) begin
            r_raw_quotient  <= div_quotient;
            r_raw_remainder <= div_remainder[OPW-1:0];
          end
        end
        ST_FIX: begin
          r_out_div_zero <= r_div_zero;
          r_out_overflow <= r_overflow;
          if (r_overflow) begin
            r_out_quotient  <= INT16_MIN_MAG;
            r_out_remainder <= 16'd0;
          end else begin
            r_out_quotient  <= w_fix_quotient;
            r_out_remainder <= w_fix_remainder;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_division_sequencer.sv
// Self-checking bench for signed_division_sequencer: a directed table, hand
// sequences for reset/backpressure/zero divisor, and random operands checked
// against integer truncating-division arithmetic. A behavioural unsigned
// divider with programmable latency sits on the divider port.
module tb_signed_division_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dividend;
  logic [15:0] in_divisor;
  logic        div_start;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_done;
  logic [15:0] div_quotient;
  logic [16:0] div_remainder;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_quotient;
  logic [15:0] out_remainder;
  logic        out_div_zero;
  logic        out_overflow;

  int n_vec = 0;
  int n_bad = 0;

  signed_division_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div_zero  (out_div_zero),
    .out_overflow  (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unsigned divider. div_done is a level that stays high from
  // the previous result until one cycle after the next start, so a sequencer
  // that takes done in its first WAIT cycle picks up stale results.
  int          div_lat = 3;
  int          dm_cnt;
  logic        dm_busy;
  logic [15:0] dm_a;
  logic [15:0] dm_b;
  int          start_count = 0;
  int          valid_count = 0;

  always @(posedge clk) begin
    if (out_valid) valid_count <= valid_count + 1;
    if (rst) begin
      div_done      <= 1'b0;
      dm_busy       <= 1'b0;
      dm_cnt        <= 0;
      div_quotient  <= 16'd0;
      div_remainder <= 17'd0;
    end else if (div_start) begin
      dm_a        <= div_dividend;
      dm_b        <= div_divisor;
      dm_cnt      <= div_lat - 1;
      dm_busy     <= 1'b1;
      start_count <= start_count + 1;
    end else if (dm_busy) begin
      if (dm_cnt <= 1) begin
        div_done <= 1'b1;
        dm_busy  <= 1'b0;
        if (dm_b == 16'd0) begin
          div_quotient  <= 16'hFFFF;
          div_remainder <= {1'($urandom % 2), dm_a};
        end else begin
          div_quotient  <= dm_a / dm_b;
          div_remainder <= {1'($urandom % 2), dm_a % dm_b};
        end
      end else begin
        div_done <= 1'b0;
        dm_cnt   <= dm_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed truncating division done with plain int arithmetic.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
    int sa, sb, qi, ri;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      dz = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
      q = 16'hFFFF;
      r = a;
`else
      // Divider yields 0xFFFF and |a|; signs are then restored.
      qi = (sa < 0) ? -65535 : 65535;
      q  = qi[15:0];
      r  = a;
`endif
    end else if (sa == -32768 && sb == -1) begin
      ov = 1'b1;
      q  = 16'h8000;
      r  = 16'h0000;
    end else begin
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[15:0];
      r  = ri[15:0];
    end
  endfunction

  function automatic int exp_latency(input logic [15:0] b, input int lat);
`ifdef DIV_ZERO_BYPASS_EN
    if (b == 16'd0) return 1;
`endif
    return 3 + lat;
  endfunction

  // One full transaction: transfer, wait for out_valid (bounded), hold under
  // backpressure for 'hold' cycles checking stability, then accept.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int lat,
                        input int hold, output logic [15:0] q, output logic [15:0] r,
                        output logic dz, output logic ov, output int latency);
    int k;
    div_lat = lat;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    latency = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        latency = i;
        break;
      end
    end
    if (latency == 0) check("out_valid_timeout", 32'd0, 32'd1);
    q  = out_quotient;
    r  = out_remainder;
    dz = out_div_zero;
    ov = out_overflow;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_quotient", 32'(out_quotient), 32'(q));
      check("hold_remainder", 32'(out_remainder), 32'(r));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        ov;
    logic [15:0] ma;
    logic [15:0] mb;
    int          lat;
    int          hold;
  } vec_t;

  vec_t        tbl [0:6];
  logic [15:0] q, r, eq, er;
  logic        dz, ov, edz, eov;
  int          lat, sc, vc;

  initial begin
    tbl[0] = '{16'd100,  16'd7,      16'd14,   16'd2,    1'b0, 16'd100,  16'd7, 3, 10};
    tbl[1] = '{16'hFF9C, 16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 16'd100,  16'd7, 4, 0};
    tbl[2] = '{16'd100,  16'hFFF9,   16'hFFF2, 16'd2,    1'b0, 16'd100,  16'd7, 2, 1};
    tbl[3] = '{16'h8000, 16'hFFFF,   16'h8000, 16'd0,    1'b1, 16'h8000, 16'd1, 5, 0};
    tbl[4] = '{16'h8000, 16'd1,      16'h8000, 16'd0,    1'b0, 16'h8000, 16'd1, 2, 0};
    tbl[5] = '{16'd9,    16'd3,      16'd3,    16'd0,    1'b0, 16'd9,    16'd3, 3, 2};
    tbl[6] = '{16'hFFF9, 16'hFFFE,   16'd3,    16'hFFFF, 1'b0, 16'd7,    16'd2, 2, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_dividend = 16'd0; in_divisor = 16'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {out_quotient, out_remainder}, 32'd0);
    check("rst_flags", {30'd0, out_div_zero, out_overflow}, 32'd0);
    check("rst_div_ops", {div_dividend, div_divisor}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      sc = start_count;
      run_op(tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].hold, q, r, dz, ov, lat);
      check("tbl_quotient", 32'(q), 32'(tbl[i].q));
      check("tbl_remainder", 32'(r), 32'(tbl[i].r));
      check("tbl_flags", {30'd0, dz, ov}, {31'd0, tbl[i].ov});
      check("tbl_latency", 32'(lat), 32'(3 + tbl[i].lat));
      check("tbl_start_pulses", 32'(start_count - sc), 32'd1);
      check("tbl_mags", {dm_a, dm_b}, {tbl[i].ma, tbl[i].mb});
    end

    // Zero divisor.
    sc = start_count;
    run_op(16'd5, 16'd0, 3, 1, q, r, dz, ov, lat);
    ref_div(16'd5, 16'd0, eq, er, edz, eov);
    check("zero_quotient", 32'(q), 32'(eq));
    check("zero_remainder", 32'(r), 32'(er));
    check("zero_flags", {30'd0, dz, ov}, 32'd2);
    check("zero_latency", 32'(lat), 32'(exp_latency(16'd0, 3)));
`ifdef DIV_ZERO_BYPASS_EN
    check("zero_no_start", 32'(start_count - sc), 32'd0);
    check("zero_quotient_ffff", 32'(q), 32'hFFFF);
`else
    check("zero_start", 32'(start_count - sc), 32'd1);
`endif

    // Reset pulsed during WAIT: operation abandoned, no result emitted.
    div_lat = 8;
    @(negedge clk);
    in_valid = 1'b1; in_dividend = 16'd1234; in_divisor = 16'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vc = valid_count;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("wait_rst_in_ready", 32'(in_ready), 32'd1);
    check("wait_rst_valid", 32'(out_valid), 32'd0);
    check("wait_rst_quotient", 32'(out_quotient), 32'd0);
    repeat (12) @(negedge clk);
    check("wait_rst_no_result", 32'(valid_count - vc), 32'd0);
    run_op(16'd9, 16'd3, 3, 0, q, r, dz, ov, lat);
    check("after_rst_quotient", 32'(q), 32'd3);
    check("after_rst_remainder", 32'(r), 32'd0);

    // Random operands against the reference.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      int          rl;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom % 8)
        0: ra = 16'h8000;
        1: rb = 16'hFFFF;
        2: rb = 16'd0;
        3: rb = 16'($urandom % 8);
        default: ;
      endcase
      rl = 2 + int'($urandom % 5);
      run_op(ra, rb, rl, int'($urandom % 3), q, r, dz, ov, lat);
      ref_div(ra, rb, eq, er, edz, eov);
      check("rnd_quotient", 32'(q), 32'(eq));
      check("rnd_remainder", 32'(r), 32'(er));
      check("rnd_flags", {30'd0, dz, ov}, {30'd0, edz, eov});
      check("rnd_latency", 32'(lat), 32'(exp_latency(rb, rl)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
